// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and default widths for the dcache queue drain logic.
package dcache_pkg;
  localparam int DATABITS_DEF = 32;
  localparam int ADDRBITS_DEF = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNTBITS_DEF = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR = 2'd1;
  localparam logic [1:0] ST_RD = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, WR = ST_WR, RD = ST_RD} state_t;
endpackage

// File: rtl/dcache_drain_timer.sv
// dcache_drain_timer: per-phase wait counter; expires after TIMEOUT running cycles, never when TIMEOUT is 0.
module dcache_drain_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? '0 : run_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire_o = (TIMEOUT > 0) && run_i && (cnt_q == TW'(TIMEOUT - 1));
endmodule

// File: rtl/dcache_queue_drain.sv
// dcache_queue_drain: pops dcache_queue entries and issues them one at a time to memory via req/ack,
// returning read data and flagging phases that time out.
module dcache_queue_drain
  import dcache_pkg::*;
#(
  parameter int DATABITS = DATABITS_DEF,
  parameter int ADDRBITS = ADDRBITS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNTBITS = CNTBITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                drain_enable,
  input  logic [DATABITS-1:0] queue_out_data,
  input  logic [ADDRBITS-1:0] queue_out_addr,
  input  logic                queue_out_rdreq,
  input  logic                queue_out_wrreq,
  input  logic                queue_not_empty,
  output logic                queue_pop,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_wdata,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  input  logic                mem_ack,
  input  logic [DATABITS-1:0] mem_rdata,
  output logic                rd_valid,
  output logic [DATABITS-1:0] rd_data,
  output logic [ADDRBITS-1:0] rd_addr,
  output logic                timeout_err,
  output logic                busy,
  output logic [CNTBITS-1:0]  xact_count
);
  state_t state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d, rdata_q, rdata_d;
  logic rd_q, rd_d, rd_valid_q, rd_valid_d, tmo_q, tmo_d;
  logic [CNTBITS-1:0] xact_q, xact_d;
  logic pop, expire;
  assign pop = (state_q == IDLE) && drain_enable && queue_not_empty;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    rd_d = rd_q;
    xact_d = xact_q;
    rdata_d = rdata_q;
    rd_valid_d = 1'b0;
    tmo_d = 1'b0;
    unique case (state_q)
      IDLE: if (pop) begin
        addr_d = queue_out_addr;
        data_d = queue_out_data;
        rd_d = queue_out_rdreq;
        state_d = queue_out_wrreq ? WR : queue_out_rdreq ? RD : IDLE;
      end
      WR: if (mem_ack) begin
        xact_d = xact_q + 1'b1;
        state_d = rd_q ? RD : IDLE;
      end else if (expire) begin
        tmo_d = 1'b1;
        state_d = IDLE;
      end
      RD: if (mem_ack) begin
        xact_d = xact_q + 1'b1;
        rdata_d = mem_rdata;
        rd_valid_d = 1'b1;
        state_d = IDLE;
      end else if (expire) begin
        tmo_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      rd_q <= 1'b0;
      xact_q <= '0;
      rdata_q <= '0;
      rd_valid_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rd_q <= rd_d;
      xact_q <= xact_d;
      rdata_q <= rdata_d;
      rd_valid_q <= rd_valid_d;
      tmo_q <= tmo_d;
    end
  // Timer restarts on every state change, so a write-then-read entry gets a fresh budget for its read.
  dcache_drain_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .load_i(state_d != state_q),
    .run_i(state_q != IDLE),
    .expire_o(expire)
  );
  assign queue_pop = pop && !reset;
  assign mem_wrreq = state_q == WR;
  assign mem_rdreq = state_q == RD;
  assign mem_addr = addr_q;
  assign mem_wdata = data_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rdata_q;
  assign rd_addr = addr_q;
  assign timeout_err = tmo_q;
  assign busy = state_q != IDLE;
  assign xact_count = xact_q;
endmodule

// File: tb/tb_dcache_queue_drain.sv
// tb_dcache_queue_drain: directed vectors against dcache_queue_drain with a small head-of-queue model.
module tb_dcache_queue_drain;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic drain_enable = 1'b0;
  logic mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] queue_out_data, queue_out_addr, mem_addr, mem_wdata, rd_data, rd_addr;
  logic queue_out_rdreq, queue_out_wrreq, queue_not_empty, queue_pop;
  logic mem_rdreq, mem_wrreq, rd_valid, timeout_err, busy;
  logic [15:0] xact_count;
  logic [31:0] q_addr [16];
  logic [31:0] q_data [16];
  logic q_rd [16];
  logic q_wr [16];
  logic [3:0] head = '0;
  logic [3:0] tail = '0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (queue_pop) head <= head + 1'b1;
  assign queue_out_addr = q_addr[head];
  assign queue_out_data = q_data[head];
  assign queue_out_rdreq = q_rd[head];
  assign queue_out_wrreq = q_wr[head];
  assign queue_not_empty = head != tail;
  dcache_queue_drain #(.DATABITS(32), .ADDRBITS(32), .TIMEOUT(4), .CNTBITS(16)) dut (
    .clk(clk), .reset(reset), .drain_enable(drain_enable),
    .queue_out_data(queue_out_data), .queue_out_addr(queue_out_addr),
    .queue_out_rdreq(queue_out_rdreq), .queue_out_wrreq(queue_out_wrreq),
    .queue_not_empty(queue_not_empty), .queue_pop(queue_pop),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_addr(rd_addr), .timeout_err(timeout_err), .busy(busy), .xact_count(xact_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
    q_addr[tail] = a;
    q_data[tail] = d;
    q_rd[tail] = rd;
    q_wr[tail] = wr;
    tail = tail + 1'b1;
  endtask
  task automatic phase(input string tag, input logic wr, input int ack_at, input logic [31:0] rdata,
                       input logic [31:0] addr, input logic [31:0] wdata);
    for (int c = 1; c <= ack_at; c++) begin
      chk({tag, "_req"}, wr ? mem_wrreq : mem_rdreq, 1);
      chk({tag, "_other"}, wr ? mem_rdreq : mem_wrreq, 0);
      chk({tag, "_addr"}, mem_addr, addr);
      if (wr) chk({tag, "_wdata"}, mem_wdata, wdata);
      if (c == ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack = 1'b0;
    mem_rdata = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_wrreq", mem_wrreq, 0);
    chk("rst_rdreq", mem_rdreq, 0);
    chk("rst_pop", queue_pop, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_cnt", xact_count, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b0;
    drain_enable = 1'b1;
    // single write, ack on third request cycle
    push(32'hdeadbeef, 32'hd00faffe, 1'b0, 1'b1);
    #1;
    chk("w_pop", queue_pop, 1);
    tick();
    chk("w_pop_end", queue_pop, 0);
    phase("w", 1'b1, 3, 32'h0, 32'hdeadbeef, 32'hd00faffe);
    chk("w_low", mem_wrreq, 0);
    chk("w_cnt", xact_count, 1);
    chk("w_busy", busy, 0);
    // ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_cnt", xact_count, 1);
    chk("idle_ack_busy", busy, 0);
    // single read
    push(32'h00001000, 32'h0, 1'b1, 1'b0);
    #1;
    chk("r_pop", queue_pop, 1);
    tick();
    phase("r", 1'b0, 2, 32'hcafef00d, 32'h00001000, 32'h0);
    chk("r_valid", rd_valid, 1);
    chk("r_data", rd_data, 32'hcafef00d);
    chk("r_addr", rd_addr, 32'h00001000);
    chk("r_cnt", xact_count, 2);
    chk("r_low", mem_rdreq, 0);
    tick();
    chk("r_valid_end", rd_valid, 0);
    // write-then-read entry
    push(32'h20, 32'h5, 1'b1, 1'b1);
    tick();
    phase("rw_w", 1'b1, 1, 32'h0, 32'h20, 32'h5);
    chk("rw_mid_rdv", rd_valid, 0);
    phase("rw_r", 1'b0, 2, 32'h12345678, 32'h20, 32'h0);
    chk("rw_valid", rd_valid, 1);
    chk("rw_data", rd_data, 32'h12345678);
    chk("rw_cnt", xact_count, 4);
    tick();
    chk("rw_valid_end", rd_valid, 0);
    chk("rw_busy", busy, 0);
    // timeout on write, then read acked on the expiry cycle
    push(32'h40, 32'h77, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", mem_wrreq, 1);
      chk("to_err_early", timeout_err, 0);
      tick();
    end
    chk("to_low", mem_wrreq, 0);
    chk("to_err", timeout_err, 1);
    chk("to_busy", busy, 0);
    chk("to_cnt", xact_count, 4);
    push(32'h44, 32'h0, 1'b1, 1'b0);
    #1;
    chk("to_next_pop", queue_pop, 1);
    tick();
    chk("to_err_end", timeout_err, 0);
    phase("tr", 1'b0, 4, 32'h0a0b0c0d, 32'h44, 32'h0);
    chk("tr_valid", rd_valid, 1);
    chk("tr_data", rd_data, 32'h0a0b0c0d);
    chk("tr_err", timeout_err, 0);
    chk("tr_cnt", xact_count, 5);
    // three entries held by drain_enable=0
    drain_enable = 1'b0;
    push(32'h100, 32'ha1, 1'b0, 1'b1);
    push(32'h104, 32'h0, 1'b1, 1'b0);
    push(32'h108, 32'ha3, 1'b0, 1'b1);
    #1;
    chk("en_hold_pop", queue_pop, 0);
    tick();
    tick();
    chk("en_hold_pop2", queue_pop, 0);
    chk("en_hold_busy", busy, 0);
    drain_enable = 1'b1;
    #1;
    chk("en_pop0", queue_pop, 1);
    tick();
    chk("en_one_flight", queue_pop, 0);
    phase("e0", 1'b1, 1, 32'h0, 32'h100, 32'ha1);
    chk("en_pop1", queue_pop, 1);
    tick();
    phase("e1", 1'b0, 1, 32'hbeef0001, 32'h104, 32'h0);
    chk("e1_valid", rd_valid, 1);
    chk("e1_data", rd_data, 32'hbeef0001);
    chk("en_pop2", queue_pop, 1);
    tick();
    drain_enable = 1'b0;
    phase("e2", 1'b1, 2, 32'h0, 32'h108, 32'ha3);
    chk("e2_pop", queue_pop, 0);
    chk("e2_cnt", xact_count, 8);
    drain_enable = 1'b1;
    // reset while waiting on a read
    push(32'h200, 32'h0, 1'b1, 1'b0);
    push(32'h204, 32'h99, 1'b0, 1'b1);
    #1;
    chk("rs_pop", queue_pop, 1);
    tick();
    chk("rs_req", mem_rdreq, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("rs_rdreq", mem_rdreq, 0);
    chk("rs_busy", busy, 0);
    chk("rs_cnt", xact_count, 0);
    chk("rs_pop_gated", queue_pop, 0);
    chk("rs_rdata", rd_data, 0);
    chk("rs_addr", mem_addr, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rs_next_pop", queue_pop, 1);
    tick();
    phase("rs_w", 1'b1, 1, 32'h0, 32'h204, 32'h99);
    chk("rs_cnt_after", xact_count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
